pe_bus_arbiter: RTL and testbench
=================================

// Module: pe_bus_arbiter
// PURPOSE
//  Round-robin arbiter granting the shared PE bus to one of N_PE PE_system instances.
//  Collects each PE's bus_request and drives the matching one-hot grant.
//  Holds the grant until the owner drops its request, or until a hold timeout when others wait.
//  Inserts one idle turnaround cycle between owners so bus drivers never overlap.
// PARAMETERS
//  N_PE      4   number of requesting PEs (2..16)
//  MAX_HOLD  16  max consecutive grant cycles while another PE waits; 0 = no limit
//  IDW       $clog2(N_PE)  width of grant_id (derived, not overridden)
// PORTS
//  clk           in   1       system clock; all state on rising edge
//  reset         in   1       asynchronous, active-low reset
//  bus_request   in   N_PE    request from PE i (level, held until done)
//  grant         out  N_PE    one-hot grant to PE i; all-zero when idle or in turnaround
//  grant_valid   out  1       OR of grant
//  grant_id      out  IDW     index of current owner; 0 when grant_valid=0
//  timeout_evt   out  1       1-cycle pulse when an owner is revoked by MAX_HOLD
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, grant=0, grant_valid=0, grant_id=0, timeout_evt=0,
//   rr_ptr=0, hold_cnt=0. Grant drops in the same instant as reset asserts, even mid-ownership.
//  All outputs are registered. No combinational path from bus_request to grant.
//  FSM states:
//   IDLE: if |bus_request, pick the winner, go to GRANT, and assert its grant next cycle.
//    Grant latency is 1 cycle: request high at edge t gives grant at t+1.
//   GRANT: owner o keeps grant while bus_request[o]=1; hold_cnt increments each cycle.
//    If bus_request[o]=0, go to TURN and deassert grant next cycle.
//    Timeout: if MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and any other request is high,
//     go to TURN, pulse timeout_evt, and revoke the grant.
//    At the timeout point with no other request, stay in GRANT and clear hold_cnt to 0.
//   TURN: exactly one cycle with grant=0. Re-arbitrate and go to GRANT, or to IDLE if no request.
//    Back-to-back owners therefore see one dead cycle between grants.
//  Winner selection:
//   First set bit of bus_request scanning upward from rr_ptr, wrapping N_PE-1 -> 0.
//   On entering GRANT for owner o, rr_ptr <= (o+1) mod N_PE; wrap is explicit for non-power-of-2 N_PE.
//   A revoked owner that still requests therefore gets lowest priority next round.
//  Requests that appear or vanish during TURN are sampled at the arbitration edge only.
//  A requester that drops before being granted is never granted; no request memory is kept.
//  hold_cnt is $clog2(MAX_HOLD+1) bits wide, saturates, and clears on every new grant.
//  Invariant: $onehot0(grant) on every cycle; grant_id is consistent with grant.
// STRUCTURE
//  pe_bus_pkg:
//   arb_state_t with IDLE=2'b00, GRANT=2'b01, TURN=2'b10; TURN is the only other legal code.
//   Default N_PE and MAX_HOLD constants.
//   Illegal state code 2'b11 recovers to IDLE.
//  Sub-module rr_pick (combinational):
//   Inputs are req[N_PE] and ptr[IDW].
//   Outputs are found and idx[IDW].
//   Implemented as a double-width masked priority encoder.
//  Top level holds the FSM, rr_ptr, hold_cnt and the output registers.
// TESTING
//  Default parameters unless stated.
//  1. Single request, reset released: req=4'b0100 at cycle 3
//     -> grant=4'b0100 and grant_id=2 at cycle 4.
//     Req dropped at cycle 10 -> grant=0 at cycle 11, state=IDLE at cycle 12.
//  2. Round robin: req=4'b1111 held, each owner drops then reasserts on its grant+1
//     -> grant order 0,1,2,3,0 with exactly one zero-grant cycle between owners.
//  3. Timeout: PE0 holds, PE2 requests from cycle 2
//     -> PE0 revoked after 16 grant cycles, timeout_evt pulse, TURN cycle, then grant=4'b0100.
//     Same scenario with only PE0 requesting -> no revoke after 40 cycles.
//  4. Wrap: rr_ptr=3 after grant to PE2, req=4'b0011 -> grant PE0, then PE1; rr_ptr returns to 2.
//     Repeat with N_PE=3 to check wrap 2->0.
//  5. Async reset mid-GRANT: reset=0 between clock edges -> grant=0 immediately.
//     After release with req=4'b1000 held -> grant to PE3 one cycle later; rr_ptr restarts from 0.
//  6. Random requests for 10k cycles -> $onehot0(grant) holds.
//     Every held request is granted within N_PE*(MAX_HOLD+1) cycles.

Source files
------------

// File: rtl/pe_bus_pkg.sv
// Shared types and defaults for the PE bus arbiter.
// The arbiter FSM encoding is fixed here so every consumer agrees on it.
package pe_bus_pkg;

    localparam int N_PE_DEF     = 4;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } arb_state_t;

    // Width of the hold counter; one bit minimum when no hold limit is configured.
    function automatic int hold_w(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

endpackage

// File: rtl/pe_bus_arbiter_rr_pick.sv
// Round-robin winner selection: first set request at or above ptr, wrapping to 0.
// Purely combinational double-width masked priority encoder.
module rr_pick #(
    parameter  int N_PE = 4,
    localparam int IDW  = $clog2(N_PE)
) (
    input  logic [N_PE-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    logic [N_PE-1:0]   masked;
    logic [2*N_PE-1:0] dbl;

    // Low half holds only requests at or above ptr; high half is the wrapped copy.
    always_comb begin
        for (int i = 0; i < N_PE; i++) begin
            masked[i] = req[i] & (IDW'(i) >= ptr);
        end
        dbl = {req, masked};
    end

    // NOTE: every output is given a default before the loop so no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int j = 2*N_PE-1; j >= 0; j--) begin
            if (dbl[j]) begin
                found = 1'b1;
                idx   = (j >= N_PE) ? IDW'(j - N_PE) : IDW'(j);
            end
        end
    end

endmodule

// File: rtl/pe_bus_arbiter.sv
// Round-robin arbiter for the shared PE bus with hold timeout and a one-cycle
// turnaround between owners. All outputs come straight from flops.
module pe_bus_arbiter
    import pe_bus_pkg::*;
#(
    parameter  int N_PE     = N_PE_DEF,
    parameter  int MAX_HOLD = MAX_HOLD_DEF,
    localparam int IDW      = $clog2(N_PE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_PE-1:0] bus_request,
    output logic [N_PE-1:0] grant,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_id,
    output logic            timeout_evt
);

    localparam int HCW = hold_w(MAX_HOLD);

    arb_state_t      state_q, state_d;
    logic [N_PE-1:0] grant_q, grant_d;
    logic            grant_valid_q, grant_valid_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
    logic            timeout_evt_q, timeout_evt_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            owner_req;
    logic            others_req;
    logic            hold_limit;

    rr_pick #(.N_PE(N_PE)) u_rr_pick (
        .req   (bus_request),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // grant_q is one-hot while in GRANT, so masking finds the owner without indexing.
    assign owner_req  = |(bus_request & grant_q);
    assign others_req = |(bus_request & ~grant_q);
    assign hold_limit = (MAX_HOLD != 0) && (hold_cnt_q == HCW'(MAX_HOLD - 1));

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_evt_d = 1'b0;

        case (state_q)
            IDLE, TURN: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                grant_id_d    = '0;
                state_d       = IDLE;
                if (pick_found) begin
                    state_d       = GRANT;
                    for (int i = 0; i < N_PE; i++) begin
                        grant_d[i] = (pick_idx == IDW'(i));
                    end
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_idx;
                    rr_ptr_d      = (pick_idx == IDW'(N_PE - 1)) ? '0 : pick_idx + 1'b1;
                    hold_cnt_d    = '0;
                end
            end

            GRANT: begin
                if (!owner_req || (hold_limit && others_req)) begin
                    state_d       = TURN;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    timeout_evt_d = owner_req;
                end else if (hold_limit) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
                grant_id_d    = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Directed and randomised checks of pe_bus_arbiter (N_PE=4 and N_PE=3 instances).
module tb_pe_bus_arbiter;
    import pe_bus_pkg::*;

    localparam int N     = 4;
    localparam int MH    = 16;
    localparam int BOUND = N * (MH + 1);

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout_evt;

    logic [2:0] req3;
    logic [2:0] grant3;
    logic       grant_valid3;
    logic [1:0] grant_id3;
    logic       timeout_evt3;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pe_bus_arbiter #(.N_PE(N), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_request (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_evt (timeout_evt)
    );

    pe_bus_arbiter #(.N_PE(3), .MAX_HOLD(MH)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .bus_request (req3),
        .grant       (grant3),
        .grant_valid (grant_valid3),
        .grant_id    (grant_id3),
        .timeout_evt (timeout_evt3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    initial begin
        int exp_owner;
        logic saw_tevt, dropped, ok;
        int wait_cnt [N];
        int max_wait;

        reset = 1'b0;
        req   = '0;
        req3  = '0;
        #3;
        check("rst_grant", grant, 0);
        check("rst_valid", grant_valid, 0);
        check("rst_id", grant_id, 0);
        check("rst_tevt", timeout_evt, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Single request, then release
        req = 4'b0100;
        tick();
        check("t1_grant", grant, 4'b0100);
        check("t1_id", grant_id, 2);
        check("t1_valid", grant_valid, 1);
        repeat (5) tick();
        check("t1_hold", grant, 4'b0100);
        req = '0;
        tick();
        check("t1_drop_grant", grant, 0);
        check("t1_drop_id", grant_id, 0);
        check("t1_turn", 32'(dut.state_q), 32'(TURN));
        tick();
        check("t1_idle", 32'(dut.state_q), 32'(IDLE));
        check("t1_ptr", dut.rr_ptr_q, 3);

        // Pointer wrap 3 -> 0 with req=0011
        req = 4'b0011;
        tick();
        check("t4_wrap_grant", grant, 4'b0001);
        check("t4_ptr1", dut.rr_ptr_q, 1);
        req = 4'b0010;
        tick();
        check("t4_gap", grant, 0);
        tick();
        check("t4_second", grant, 4'b0010);
        check("t4_ptr2", dut.rr_ptr_q, 2);
        req = '0;
        repeat (2) tick();
        check("t4_idle", 32'(dut.state_q), 32'(IDLE));

        // Round robin over all four with one dead cycle between owners
        do_reset();
        req = 4'hF;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_owner = k % 4;
            check("t2_owner", grant, 32'(1) << exp_owner);
            check("t2_id", grant_id, exp_owner);
            repeat (2) tick();
            req[exp_owner] = 1'b0;
            tick();
            check("t2_gap", grant, 0);
            req[exp_owner] = 1'b1;
            tick();
        end

        // Timeout: PE0 holds, PE2 waits
        req = '0;
        do_reset();
        req = 4'b0001;
        tick();
        check("t3_grant", grant, 4'b0001);
        req = 4'b0101;
        saw_tevt = 1'b0;
        dropped  = 1'b0;
        for (int i = 1; i < MH; i++) begin
            tick();
            if (grant != 4'b0001) dropped = 1'b1;
            if (timeout_evt) saw_tevt = 1'b1;
        end
        check("t3_held16", dropped, 0);
        check("t3_no_early_tevt", saw_tevt, 0);
        tick();
        check("t3_revoke", grant, 0);
        check("t3_tevt", timeout_evt, 1);
        tick();
        check("t3_next", grant, 4'b0100);
        check("t3_tevt_pulse", timeout_evt, 0);

        // Lone requester is never revoked
        req = '0;
        do_reset();
        req = 4'b0001;
        tick();
        saw_tevt = 1'b0;
        dropped  = 1'b0;
        repeat (40) begin
            tick();
            if (grant != 4'b0001) dropped = 1'b1;
            if (timeout_evt) saw_tevt = 1'b1;
        end
        check("t3_lone_held", dropped, 0);
        check("t3_lone_tevt", saw_tevt, 0);

        // Async reset mid-grant drops grant before any edge
        #2 reset = 1'b0;
        #1;
        check("t5_async_grant", grant, 0);
        check("t5_async_valid", grant_valid, 0);
        req = 4'b1000;
        #1 reset = 1'b1;
        tick();
        check("t5_grant", grant, 4'b1000);
        check("t5_id", grant_id, 3);
        check("t5_ptr", dut.rr_ptr_q, 0);

        // N_PE=3: wrap 2 -> 0
        req = '0;
        do_reset();
        req3 = 3'b100;
        tick();
        check("n3_grant2", grant3, 3'b100);
        check("n3_ptr_wrap", dut3.rr_ptr_q, 0);
        req3 = 3'b011;
        tick();
        check("n3_gap", grant3, 0);
        tick();
        check("n3_wrap", grant3, 3'b001);
        req3 = '0;

        // Random traffic: invariants and bounded wait
        do_reset();
        max_wait = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            tick();
            ok = $onehot0(grant) && (grant_valid == |grant) &&
                 (grant_valid ? (grant == (4'b0001 << grant_id)) : (grant_id == 2'd0));
            check("rand_inv", ok, 1);
            for (int i = 0; i < N; i++) begin
                if (req[i] && !grant[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                if (req[i] && grant[i]) begin
                    if ($urandom_range(7) == 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(3) == 0) req[i] = 1'b1;
                end
            end
        end
        check("rand_wait_bound", max_wait <= BOUND, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
